filter_input_buffer: RTL and testbench
======================================

Name: filter_input_buffer

Overview:
- Circular FIFO that stages filter words arriving from the memory/interface side.
- Feeds the filter-scratchpad read controller directly downstream of it.
- Presents its head word combinationally (show-ahead) with a `valid` flag, so the controller can pop with `ren_buf` and write the filter scratchpad in the same cycle.
- Tracks occupancy and raises sticky overflow/underflow error flags.

Parameters:
- DATA_WIDTH, 16, width of one filter word.
- DEPTH, 8, number of entries; any value ≥ 2, not required to be a power of 2.
- ADDR_WIDTH, 3, pointer width; must satisfy 2^ADDR_WIDTH ≥ DEPTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately).
- clear  input  1  synchronous flush; empties the buffer and clears error flags.
- din  input  DATA_WIDTH  write data.
- wen  input  1  write request from upstream.
- full  output  1  buffer holds DEPTH entries.
- ren  input  1  pop request (driven by the downstream controller's `ren_buf`).
- dout  output  DATA_WIDTH  head entry, combinational from storage at read pointer.
- valid  output  1  buffer non-empty; dout is meaningful.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- err_ovf  output  1  sticky: a write was attempted while full and not accepted.
- err_udf  output  1  sticky: a pop was attempted while empty.

Behaviour:

Reset (rst=0, asynchronous):
- wptr=0, rptr=0, count=0.
- full=0, valid=0, err_ovf=0, err_udf=0.
- dout is don't-care; a bench must not check it while valid=0.
- Storage array is not reset.

Clear (clear=1, synchronous):
- Next edge sets wptr=rptr=count=0 and err_ovf=err_udf=0.
- Overrides any wen/ren in the same cycle; nothing is written or popped.

Acceptance:
- push_ok = wen & (~full | ren).
  - Write while full is accepted only if a pop happens the same cycle.
- pop_ok = ren & valid.
  - Pop while empty is ignored, even if wen=1 the same cycle; there is no fall-through.

Write path:
- On push_ok: mem[wptr] <= din.
- wptr advances by 1 and wraps from DEPTH-1 to 0 (explicit compare, not a power-of-2 overflow).

Read path:
- dout = mem[rptr], combinational.
- On pop_ok: rptr advances with the same wrap rule.
- New head is visible on dout in the cycle after the pop edge.

Latency:
- A word written at edge N appears on dout with valid=1 after edge N (zero-bubble when previously empty).

Count:
- count <= count + push_ok - pop_ok.
- full = (count==DEPTH); valid = (count!=0). Both are decoded from registered count, never from pointer equality.

Simultaneous push and pop:
- Non-empty, non-full: count unchanged, both pointers advance.
- Full: both accepted, count stays DEPTH, full stays 1.
- Empty: push only; count becomes 1.

Error flags:
- err_ovf <= 1 on wen & full & ~ren.
- err_udf <= 1 on ren & ~valid.
- Both hold until clear or reset.

Downstream interaction:
- The controller may hold `ren` low while stalled; buffer contents and dout stay stable.
- The buffer has no stall input.

Reset mid-operation:
- Asserting rst at any time empties the buffer immediately.
- valid drops without waiting for a clock edge.

Test Plan:
1. Reset then fill: rst low 2 cycles, release; write 0x0001..0x0008 on consecutive cycles with ren=0 → count steps 1..8, full=1 after the 8th edge, valid=1 from the first edge, dout=0x0001 throughout.
2. Overflow while full: from scenario 1, wen=1 din=0xDEAD, ren=0 → count stays 8, err_ovf=1 and remains 1. Then drain 8 pops → dout sequence 0x0001..0x0008, valid=0 after the last pop, 0xDEAD never appears.
3. Pop while empty: empty buffer, ren=1 one cycle → count=0, err_udf=1. Then clear=1 one cycle → err_udf=0, err_ovf=0.
4. Concurrent push/pop, including wrap: write 5 words, then 12 cycles of wen=ren=1 with din=0x0100+i → count stays 5 throughout. Pointers wrap; output order is the 5 initial words followed by 0x0100.. in order.
5. Push/pop when full and when empty: full buffer with wen=ren=1 → count=8, full=1, err_ovf=0, head advances. Empty buffer with wen=ren=1 din=0x0042 → count=1, dout=0x0042, err_udf=1.
6. Async reset mid-stream: 4 entries stored, drop rst between clock edges → valid=0 and count=0 before the next edge. After release, the first write of 0x00AA appears on dout.

Source files
------------

// File: rtl/filter_input_buffer.sv
// rtl/filter_input_buffer.sv - show-ahead circular FIFO staging filter words for the scratchpad read controller
module filter_input_buffer #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  wen,
   output logic                  full,
   input  logic                  ren,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  valid,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  err_ovf,
   output logic                  err_udf
);

   // Wrap point is an explicit compare so DEPTH need not be a power of two.
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0]   DEPTH_CNT  = (ADDR_WIDTH + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wptr;
   logic [ADDR_WIDTH-1:0] rptr;
   logic [ADDR_WIDTH:0]   cnt;
   logic                  push_ok;
   logic                  pop_ok;

   // Flags come from the registered occupancy, never from pointer equality.
   assign full  = (cnt == DEPTH_CNT);
   assign valid = (cnt != '0);
   assign count = cnt;

   // A write while full is legal only when the head leaves in the same cycle;
   // a pop on an empty buffer never falls through to the incoming word.
   assign push_ok = wen & (~full | ren);
   assign pop_ok  = ren & valid;

   // Head word is presented combinationally so the controller can pop and use it in one cycle.
   assign dout = mem[rptr];

   // Storage array: written on accepted pushes only, intentionally not reset.
   always_ff @(posedge clk) begin
      if (push_ok && !clear) begin
         mem[wptr] <= din;
      end
   end

   // Pointers, occupancy and sticky error flags; clear flushes everything and wins over wen/ren.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr    <= '0;
         rptr    <= '0;
         cnt     <= '0;
         err_ovf <= 1'b0;
         err_udf <= 1'b0;
      end else if (clear) begin
         wptr    <= '0;
         rptr    <= '0;
         cnt     <= '0;
         err_ovf <= 1'b0;
         err_udf <= 1'b0;
      end else begin
         if (push_ok) begin
            wptr <= (wptr == LAST_IDX) ? '0 : wptr + 1'b1;
         end
         if (pop_ok) begin
            rptr <= (rptr == LAST_IDX) ? '0 : rptr + 1'b1;
         end
         if (push_ok && !pop_ok) begin
            cnt <= cnt + 1'b1;
         end else if (pop_ok && !push_ok) begin
            cnt <= cnt - 1'b1;
         end
         if (wen && full && !ren) begin
            err_ovf <= 1'b1;
         end
         if (ren && !valid) begin
            err_udf <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_filter_input_buffer.sv
// tb/tb_filter_input_buffer.sv - scoreboard bench for filter_input_buffer
module tb_filter_input_buffer;

   logic        clk;
   logic        rst;
   logic        clear;
   logic [15:0] din;
   logic        wen;
   logic        full;
   logic        ren;
   logic [15:0] dout;
   logic        valid;
   logic [3:0]  count;
   logic        err_ovf;
   logic        err_udf;

   int checks;
   int errors;
   logic [15:0] exp_q [$];

   filter_input_buffer #(
      .DATA_WIDTH(16),
      .DEPTH(8),
      .ADDR_WIDTH(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .clear(clear),
      .din(din),
      .wen(wen),
      .full(full),
      .ren(ren),
      .dout(dout),
      .valid(valid),
      .count(count),
      .err_ovf(err_ovf),
      .err_udf(err_udf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Monitor: mid-cycle, any pop the DUT is about to take must deliver the scoreboard head.
   always @(negedge clk) begin
      if (rst && !clear && ren && valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_unexpected actual=%0h expected=none", dout);
         end else begin
            chk("pop_data", {16'h0, dout}, {16'h0, exp_q.pop_front()});
         end
      end
   end

   // One clock with the given inputs, then back to idle; returns at posedge+1.
   task automatic drive(input logic w, input logic [15:0] d, input logic r, input logic c);
      wen   = w;
      din   = d;
      ren   = r;
      clear = c;
      @(posedge clk);
      #1;
      wen   = 1'b0;
      ren   = 1'b0;
      clear = 1'b0;
      din   = 16'h0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b0;
      clear  = 1'b0;
      wen    = 1'b0;
      ren    = 1'b0;
      din    = 16'h0;

      // 1: reset then fill
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", {28'h0, count}, 32'd0);
      chk("rst_valid", {31'h0, valid}, 32'd0);
      chk("rst_full", {31'h0, full}, 32'd0);
      chk("rst_err_ovf", {31'h0, err_ovf}, 32'd0);
      chk("rst_err_udf", {31'h0, err_udf}, 32'd0);
      rst = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         exp_q.push_back(16'(i));
         drive(1'b1, 16'(i), 1'b0, 1'b0);
         chk("fill_count", {28'h0, count}, 32'(i));
         chk("fill_valid", {31'h0, valid}, 32'd1);
         chk("fill_head", {16'h0, dout}, 32'h0001);
         chk("fill_full", {31'h0, full}, (i == 8) ? 32'd1 : 32'd0);
      end

      // 2: overflow while full, then drain
      drive(1'b1, 16'hDEAD, 1'b0, 1'b0);
      chk("ovf_count", {28'h0, count}, 32'd8);
      chk("ovf_flag", {31'h0, err_ovf}, 32'd1);
      drive(1'b0, 16'h0, 1'b0, 1'b0);
      chk("ovf_sticky", {31'h0, err_ovf}, 32'd1);
      for (int i = 0; i < 8; i++) drive(1'b0, 16'h0, 1'b1, 1'b0);
      chk("drain_valid", {31'h0, valid}, 32'd0);
      chk("drain_count", {28'h0, count}, 32'd0);
      chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);

      // 3: pop while empty, then clear
      drive(1'b0, 16'h0, 1'b1, 1'b0);
      chk("udf_count", {28'h0, count}, 32'd0);
      chk("udf_flag", {31'h0, err_udf}, 32'd1);
      drive(1'b0, 16'h0, 1'b0, 1'b1);
      chk("clr_err_udf", {31'h0, err_udf}, 32'd0);
      chk("clr_err_ovf", {31'h0, err_ovf}, 32'd0);

      // 4: concurrent push/pop with pointer wrap
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(16'h0011 + 16'(i));
         drive(1'b1, 16'h0011 + 16'(i), 1'b0, 1'b0);
      end
      for (int i = 0; i < 12; i++) begin
         exp_q.push_back(16'h0100 + 16'(i));
         drive(1'b1, 16'h0100 + 16'(i), 1'b1, 1'b0);
         chk("conc_count", {28'h0, count}, 32'd5);
      end
      for (int i = 0; i < 5; i++) drive(1'b0, 16'h0, 1'b1, 1'b0);
      chk("conc_count_end", {28'h0, count}, 32'd0);
      chk("conc_sb_empty", 32'(exp_q.size()), 32'd0);

      // 5a: push+pop when full
      for (int i = 1; i <= 8; i++) begin
         exp_q.push_back(16'h0200 + 16'(i));
         drive(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0);
      end
      exp_q.push_back(16'h0300);
      drive(1'b1, 16'h0300, 1'b1, 1'b0);
      chk("fullpp_count", {28'h0, count}, 32'd8);
      chk("fullpp_full", {31'h0, full}, 32'd1);
      chk("fullpp_err_ovf", {31'h0, err_ovf}, 32'd0);
      chk("fullpp_head", {16'h0, dout}, 32'h0202);
      for (int i = 0; i < 8; i++) drive(1'b0, 16'h0, 1'b1, 1'b0);
      chk("fullpp_sb_empty", 32'(exp_q.size()), 32'd0);

      // 5b: push+pop when empty (push only)
      exp_q.push_back(16'h0042);
      drive(1'b1, 16'h0042, 1'b1, 1'b0);
      chk("emptypp_count", {28'h0, count}, 32'd1);
      chk("emptypp_head", {16'h0, dout}, 32'h0042);
      chk("emptypp_err_udf", {31'h0, err_udf}, 32'd1);
      exp_q.delete();
      drive(1'b0, 16'h0, 1'b0, 1'b1);
      chk("clr2_count", {28'h0, count}, 32'd0);

      // 6: async reset mid-stream
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(16'h0050 + 16'(i));
         drive(1'b1, 16'h0050 + 16'(i), 1'b0, 1'b0);
      end
      chk("pre_rst_count", {28'h0, count}, 32'd4);
      #2;
      rst = 1'b0;
      exp_q.delete();
      #1;
      chk("async_rst_valid", {31'h0, valid}, 32'd0);
      chk("async_rst_count", {28'h0, count}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.push_back(16'h00AA);
      drive(1'b1, 16'h00AA, 1'b0, 1'b0);
      chk("post_rst_head", {16'h0, dout}, 32'h00AA);
      chk("post_rst_valid", {31'h0, valid}, 32'd1);
      drive(1'b0, 16'h0, 1'b1, 1'b0);
      chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
      chk("final_valid", {31'h0, valid}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
